// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Multicycle sequencer for a small processor datapath (PC, instruction memory,
//   IR, register file, ALU, data memory). Each instruction is stepped through
//   FETCH / DECODE / execute-class states. All datapath enables and selects are
//   decoded from the state register. The only exception is the IR fields that
//   qualify a state (condition result, i_bit, opcode, u_bit).
//
//   Inputs : clk, rst (async, active-high), start (run level),
//            cond/op/i_bit/opcode/u_bit/s_bit/l_bit (IR fields), alu_flags (NZCV)
//   Outputs: pc_we, pc_src, ir_we, reg_we, mem_we, alu_src_b, alu_ctrl[1:0],
//            imm_src[1:0], result_sel, flags[3:0] (registered NZCV), busy,
//            instr_done (last state of an instruction), illegal (DECODE only)
module multicycle_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] cond,
   input  logic [1:0] op,
   input  logic       i_bit,
   input  logic [3:0] opcode,
   input  logic       u_bit,
   input  logic       s_bit,
   input  logic       l_bit,
   input  logic [3:0] alu_flags,
   output logic       pc_we,
   output logic       pc_src,
   output logic       ir_we,
   output logic       reg_we,
   output logic       mem_we,
   output logic       alu_src_b,
   output logic [1:0] alu_ctrl,
   output logic [1:0] imm_src,
   output logic       result_sel,
   output logic [3:0] flags,
   output logic       busy,
   output logic       instr_done,
   output logic       illegal
);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_EXECUTE  = 4'd3,
      S_ALUWB    = 4'd4,
      S_MEMADR   = 4'd5,
      S_MEMREAD  = 4'd6,
      S_MEMWB    = 4'd7,
      S_MEMWRITE = 4'd8,
      S_BRANCH   = 4'd9
   } state_t;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   localparam logic [1:0] IMM_DP  = 2'b00;
   localparam logic [1:0] IMM_MEM = 2'b01;
   localparam logic [1:0] IMM_BR  = 2'b10;

   state_t     state_q, state_d;
   logic [3:0] flags_q, flags_d;

   logic       opcode_ok;
   logic       decode_illegal;
   logic       decode_noop;
   logic [1:0] dp_alu_ctrl;
   logic [1:0] mem_alu_ctrl;
   logic       next_is_fetch;

   function automatic logic cond_pass(input logic [3:0] cc, input logic [3:0] nzcv);
      logic n, z, c, v;
      {n, z, c, v} = nzcv;
      case (cc)
         4'b0000: cond_pass = z;
         4'b0001: cond_pass = !z;
         4'b0010: cond_pass = c;
         4'b0011: cond_pass = !c;
         4'b0100: cond_pass = n;
         4'b0101: cond_pass = !n;
         4'b0110: cond_pass = v;
         4'b0111: cond_pass = !v;
         4'b1000: cond_pass = c & !z;
         4'b1001: cond_pass = !c | z;
         4'b1010: cond_pass = (n == v);
         4'b1011: cond_pass = (n != v);
         4'b1100: cond_pass = !z & (n == v);
         4'b1101: cond_pass = z | (n != v);
         4'b1110: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   endfunction

   // DP opcode decode: only ADD/SUB/AND/ORR are implemented.
   always_comb begin
      opcode_ok   = 1'b1;
      dp_alu_ctrl = ALU_ADD;
      case (opcode)
         4'b0100: dp_alu_ctrl = ALU_ADD;
         4'b0010: dp_alu_ctrl = ALU_SUB;
         4'b0000: dp_alu_ctrl = ALU_AND;
         4'b1100: dp_alu_ctrl = ALU_ORR;
         default: opcode_ok   = 1'b0;
      endcase
   end

   // illegal reflects the encoding alone; a failed condition only turns the
   // instruction into a silent no-op.
   assign decode_illegal = (op == 2'b11) || ((op == 2'b00) && !opcode_ok);
   assign decode_noop    = decode_illegal || !cond_pass(cond, flags_q);
   assign mem_alu_ctrl   = u_bit ? ALU_ADD : ALU_SUB;
   assign next_is_fetch  = start;

   // State and flag registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         flags_q <= 4'b0000;
      end else begin
         state_q <= state_d;
         flags_q <= flags_d;
      end
   end

   // Next-state logic; every "instruction ends" state returns via next_is_fetch.
   always_comb begin
      state_d = state_q;
      flags_d = flags_q;
      case (state_q)
         S_IDLE:     state_d = start ? S_FETCH : S_IDLE;
         S_FETCH:    state_d = S_DECODE;
         S_DECODE: begin
            if (decode_noop)        state_d = next_is_fetch ? S_FETCH : S_IDLE;
            else if (op == 2'b00)   state_d = S_EXECUTE;
            else if (op == 2'b01)   state_d = S_MEMADR;
            else                    state_d = S_BRANCH;
         end
         S_EXECUTE: begin
            state_d = S_ALUWB;
            if (s_bit) flags_d = alu_flags;
         end
         S_ALUWB:    state_d = next_is_fetch ? S_FETCH : S_IDLE;
         S_MEMADR:   state_d = l_bit ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = S_MEMWB;
         S_MEMWB:    state_d = next_is_fetch ? S_FETCH : S_IDLE;
         S_MEMWRITE: state_d = next_is_fetch ? S_FETCH : S_IDLE;
         S_BRANCH:   state_d = next_is_fetch ? S_FETCH : S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // Output decode; anything not set for a state stays 0.
   always_comb begin
      pc_we      = 1'b0;
      pc_src     = 1'b0;
      ir_we      = 1'b0;
      reg_we     = 1'b0;
      mem_we     = 1'b0;
      alu_src_b  = 1'b0;
      alu_ctrl   = ALU_ADD;
      imm_src    = IMM_DP;
      result_sel = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
      busy       = (state_q != S_IDLE);
      case (state_q)
         S_FETCH: begin
            ir_we = 1'b1;
            pc_we = 1'b1;
         end
         S_DECODE: begin
            instr_done = decode_noop;
            illegal    = decode_illegal;
         end
         S_EXECUTE: begin
            alu_src_b = i_bit;
            alu_ctrl  = dp_alu_ctrl;
         end
         S_ALUWB: begin
            reg_we     = 1'b1;
            instr_done = 1'b1;
         end
         S_MEMADR, S_MEMREAD: begin
            alu_src_b = 1'b1;
            imm_src   = IMM_MEM;
            alu_ctrl  = mem_alu_ctrl;
         end
         S_MEMWB: begin
            reg_we     = 1'b1;
            result_sel = 1'b1;
            instr_done = 1'b1;
         end
         S_MEMWRITE: begin
            alu_src_b  = 1'b1;
            imm_src    = IMM_MEM;
            alu_ctrl   = mem_alu_ctrl;
            mem_we     = 1'b1;
            instr_done = 1'b1;
         end
         S_BRANCH: begin
            imm_src    = IMM_BR;
            pc_we      = 1'b1;
            pc_src     = 1'b1;
            instr_done = 1'b1;
         end
         default: ;
      endcase
   end

   assign flags = flags_q;

   // ALU_ORR/ALU_AND only appear through dp_alu_ctrl; keep them referenced.
   logic unused_ok;
   assign unused_ok = (ALU_ORR != ALU_AND);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver pushes the expected
// per-cycle output trace of each instruction; the monitor collects the DUT's
// trace and compares it when instr_done is presented.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst, start;
   logic [3:0] cond, opcode, alu_flags, flags;
   logic [1:0] op, alu_ctrl, imm_src;
   logic       i_bit, u_bit, s_bit, l_bit;
   logic       pc_we, pc_src, ir_we, reg_we, mem_we, alu_src_b, result_sel;
   logic       busy, instr_done, illegal;

   always #5 clk = ~clk;

   multicycle_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .cond(cond), .op(op), .i_bit(i_bit),
      .opcode(opcode), .u_bit(u_bit), .s_bit(s_bit), .l_bit(l_bit),
      .alu_flags(alu_flags), .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we),
      .reg_we(reg_we), .mem_we(mem_we), .alu_src_b(alu_src_b),
      .alu_ctrl(alu_ctrl), .imm_src(imm_src), .result_sel(result_sel),
      .flags(flags), .busy(busy), .instr_done(instr_done), .illegal(illegal)
   );

   typedef struct packed {
      logic [3:0] cond;
      logic [1:0] op;
      logic       i;
      logic [3:0] opc;
      logic       s;
      logic [3:0] af;
   } instr_t;

   typedef struct packed {
      logic [3:0]       len;
      logic [7:0][13:0] w;
      logic [3:0]       flags;
   } exp_t;

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;
   bit idle   = 1'b1;
   logic [3:0] m_flags = 4'b0000;
   exp_t exp_q[$];
   logic [13:0] trace[$];
   exp_t mon_e;

   logic [13:0] obs_w;
   assign obs_w = {pc_we, pc_src, ir_we, reg_we, mem_we, alu_src_b, alu_ctrl,
                   imm_src, result_sel, busy, instr_done, illegal};

   function automatic logic [13:0] mk(input logic pcw, input logic pcs, input logic irw,
                                      input logic rw, input logic mw, input logic asb,
                                      input logic [1:0] ac, input logic [1:0] is,
                                      input logic rs, input logic b, input logic d,
                                      input logic il);
      return {pcw, pcs, irw, rw, mw, asb, ac, is, rs, b, d, il};
   endfunction

   // Reference model: expected output trace of one instruction from FETCH on.
   function automatic exp_t model(input instr_t in, input logic [3:0] f);
      exp_t e;
      logic n, z, c, v, base, pass, bad;
      logic [1:0] actl, mactl;
      logic [13:0] addr;
      {n, z, c, v} = f;
      case (in.cond[3:1])
         3'd0: base = z;
         3'd1: base = c;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = c & !z;
         3'd5: base = (n == v);
         3'd6: base = !z & (n == v);
         default: base = 1'b1;
      endcase
      pass = in.cond[0] ? !base : base;   // odd codes are the negation of the even one
      bad  = (in.op == 2'd3) || (in.op == 2'd0 && !(in.opc inside {4'd4, 4'd2, 4'd0, 4'd12}));
      case (in.opc)
         4'd2:    actl = 2'd1;
         4'd0:    actl = 2'd2;
         4'd12:   actl = 2'd3;
         default: actl = 2'd0;
      endcase
      e       = '0;
      e.flags = f;
      e.w[0]  = mk(1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 0, 1, 0, 0);
      e.w[1]  = mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 0, 0);
      if (!pass || bad) begin
         e.len  = 4'd2;
         e.w[1] = mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0, 1, 1, bad);
      end else if (in.op == 2'd0) begin
         e.len  = 4'd4;
         e.w[2] = mk(0, 0, 0, 0, 0, in.i, actl, 2'd0, 0, 1, 0, 0);
         e.w[3] = mk(0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 0, 1, 1, 0);
         if (in.s) e.flags = in.af;
      end else if (in.op == 2'd1) begin
         mactl  = in.opc[2] ? 2'd0 : 2'd1;
         addr   = mk(0, 0, 0, 0, 0, 1, mactl, 2'd1, 0, 1, 0, 0);
         e.w[2] = addr;
         if (in.s) begin
            e.len  = 4'd5;
            e.w[3] = addr;
            e.w[4] = mk(0, 0, 0, 1, 0, 0, 2'd0, 2'd0, 1, 1, 1, 0);
         end else begin
            e.len  = 4'd4;
            e.w[3] = mk(0, 0, 0, 0, 1, 1, mactl, 2'd1, 0, 1, 1, 0);
         end
      end else begin
         e.len  = 4'd3;
         e.w[2] = mk(1, 1, 0, 0, 0, 0, 2'd0, 2'd2, 0, 1, 1, 0);
      end
      return e;
   endfunction

   // Monitor: checks idle outputs and compares each completed instruction trace.
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         if (!busy) begin
            checks++;
            if (obs_w !== 14'd0) begin
               errors++;
               $display("FAIL idle_outputs: got %h expected 0000", obs_w);
            end
            if (trace.size() != 0) begin
               errors++;
               $display("FAIL abandoned_instr: %0d cycles without instr_done", trace.size());
               trace.delete();
            end
         end else begin
            trace.push_back(obs_w);
            if (instr_done) begin
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_done: got instr_done expected none pending");
               end else begin
                  mon_e = exp_q.pop_front();
                  checks++;
                  if (trace.size() != int'(mon_e.len)) begin
                     errors++;
                     $display("FAIL instr_len: got %0d expected %0d", trace.size(), mon_e.len);
                  end
                  for (int i = 0; i < int'(mon_e.len); i++) begin
                     if (i < trace.size()) begin
                        checks++;
                        if (trace[i] !== mon_e.w[i]) begin
                           errors++;
                           $display("FAIL cycle%0d_outputs: got %h expected %h", i, trace[i], mon_e.w[i]);
                        end
                     end
                  end
                  checks++;
                  if (flags !== mon_e.flags) begin
                     errors++;
                     $display("FAIL flags: got %b expected %b", flags, mon_e.flags);
                  end
               end
               trace.delete();
            end else if (trace.size() > 8) begin
               checks++; errors++;
               $display("FAIL no_instr_done: got %0d busy cycles expected at most 5", trace.size());
               trace.delete();
            end
         end
      end
   end

   task automatic apply(input instr_t in);
      cond = in.cond; op = in.op; i_bit = in.i; opcode = in.opc;
      u_bit = in.opc[2]; s_bit = in.s; l_bit = in.s; alu_flags = in.af;
   endtask

   // Called #1 after a posedge with the DUT in IDLE or FETCH; returns the same way.
   task automatic issue(input instr_t in, input int drop_at, input bit resume);
      exp_t e;
      bit ended;
      ended = 1'b0;
      apply(in);
      e = model(in, m_flags);
      m_flags = e.flags;
      exp_q.push_back(e);
      start = 1'b1;
      if (idle) begin @(posedge clk); #1; end
      for (int c = 0; c < 12; c++) begin
         if (c == drop_at) start = 1'b0;
         if (resume && drop_at >= 0 && c == drop_at + 1) start = 1'b1;
         @(negedge clk);
         if (instr_done) begin ended = 1'b1; break; end
         @(posedge clk); #1;
      end
      if (!ended) begin
         checks++; errors++;
         $display("FAIL instr_timeout: got no instr_done expected within 12 cycles");
      end
      idle = !start;
      @(posedge clk); #1;
   endtask

   function automatic instr_t rand_instr();
      instr_t in;
      logic [3:0] valid_opc [4] = '{4'd4, 4'd2, 4'd0, 4'd12};
      in.cond = ($urandom_range(0, 99) < 55) ? 4'b1110 : 4'($urandom_range(0, 15));
      in.op   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      in.opc  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                             : valid_opc[$urandom_range(0, 3)];
      in.i    = 1'($urandom_range(0, 1));
      in.s    = 1'($urandom_range(0, 1));
      in.af   = 4'($urandom_range(0, 15));
      if (in.op == 2'd3 || (in.op == 2'd0 && !(in.opc inside {4'd4, 4'd2, 4'd0, 4'd12})))
         in.cond = 4'b1110;
      return in;
   endfunction

   initial begin
      int r, drop;
      bit res;
      rst = 1'b1; start = 1'b0;
      apply('0);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (obs_w !== 14'd0) begin errors++; $display("FAIL reset_outputs: got %h expected 0000", obs_w); end
      checks++;
      if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", flags); end
      @(negedge clk) rst = 1'b0;
      mon_en = 1'b1;
      @(posedge clk); #1;

      // cond, op, i, opc, s, af
      issue('{4'hE, 2'd0, 1'b0, 4'd4,  1'b1, 4'b0100}, -1, 0);  // ADD S, flags <- 0100
      issue('{4'hE, 2'd1, 1'b1, 4'd0,  1'b1, 4'b1111}, -1, 0);  // LDR, u=0
      issue('{4'hE, 2'd1, 1'b0, 4'd4,  1'b0, 4'b1111}, -1, 0);  // STR, u=1
      issue('{4'h0, 2'd2, 1'b0, 4'd0,  1'b0, 4'b0000}, -1, 0);  // B EQ taken (Z=1)
      issue('{4'hE, 2'd0, 1'b1, 4'd2,  1'b1, 4'b0000}, -1, 0);  // SUB S, flags <- 0000
      issue('{4'h0, 2'd2, 1'b0, 4'd0,  1'b0, 4'b0000}, -1, 0);  // B EQ not taken
      issue('{4'hE, 2'd3, 1'b0, 4'd4,  1'b0, 4'b0000}, -1, 0);  // op=11
      issue('{4'hE, 2'd0, 1'b0, 4'd15, 1'b1, 4'b1111}, -1, 0);  // DP opcode 1111
      issue('{4'hE, 2'd0, 1'b0, 4'd0,  1'b0, 4'b0000},  2, 0);  // start dropped in EXECUTE
      repeat (3) begin @(posedge clk); #1; end
      issue('{4'hE, 2'd0, 1'b1, 4'd12, 1'b1, 4'b1001},  0, 1);  // start glitch in FETCH
      issue('{4'hF, 2'd0, 1'b0, 4'd4,  1'b1, 4'b0110}, -1, 0);  // NV never executes

      for (int k = 0; k < 200; k++) begin
         r = $urandom_range(0, 99);
         drop = -1; res = 1'b0;
         if (r < 15) drop = $urandom_range(0, 4);
         else if (r < 25) begin drop = 0; res = 1'b1; end
         issue(rand_instr(), drop, res);
         if (idle) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end

      issue('{4'hE, 2'd0, 1'b0, 4'd4, 1'b1, 4'b1010}, 0, 0);    // leave flags nonzero, stop
      repeat (2) begin @(posedge clk); #1; end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL pending_expected: got %0d expected 0", exp_q.size()); end

      // Asynchronous reset in the middle of an LDR (MEMREAD state).
      mon_en = 1'b0;
      apply('{4'hE, 2'd1, 1'b0, 4'd0, 1'b1, 4'b0101});
      start = 1'b1;
      @(posedge clk); #1;                          // FETCH
      repeat (3) begin @(posedge clk); #1; end     // DECODE, MEMADR, MEMREAD
      @(negedge clk);
      checks++;
      if (obs_w !== mk(0, 0, 0, 0, 0, 1, 2'd1, 2'd1, 0, 1, 0, 0)) begin
         errors++;
         $display("FAIL memread_outputs: got %h expected %h", obs_w, mk(0, 0, 0, 0, 0, 1, 2'd1, 2'd1, 0, 1, 0, 0));
      end
      checks++;
      if (flags !== 4'b1010) begin errors++; $display("FAIL memread_flags: got %b expected 1010", flags); end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (obs_w !== 14'd0) begin errors++; $display("FAIL async_reset_outputs: got %h expected 0000", obs_w); end
      checks++;
      if (flags !== 4'b0000) begin errors++; $display("FAIL async_reset_flags: got %b expected 0000", flags); end
      start = 1'b0;
      @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (obs_w !== 14'd0) begin errors++; $display("FAIL post_reset_idle: got %h expected 0000", obs_w); end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
